ms_timer_scheduler: RTL and testbench

- Shares one millisecond timebase among NUM_CH independent countdown channels.
- Typical users: dealer-card delay, display blink and player timeout in the blackjack controller.
- Divides clk into a one-cycle tick. On each tick, a sweep FSM services every channel through one shared decrementer.
- Each channel raises busy while counting and emits a one-cycle done pulse on expiry. A free-running ms count is also exported.

---
 rtl/ms_timer_scheduler.sv | 173 +++++++++++++++++
 tb/tb_ms_timer_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_timer_scheduler.sv
// ms_timer_scheduler
//   One millisecond timebase shared by NUM_CH independent countdown channels.
//   A prescaler divides clk down to a one-cycle tick. After each tick a sweep
//   FSM visits every channel once, one channel per cycle, and pushes it
//   through a single shared decrementer. A channel expires during the sweep
//   of the D-th tick after its start.
//
//   Parameters
//     CLK_HZ   clk frequency in Hz
//     TICK_HZ  tick rate in Hz (DIV = CLK_HZ / TICK_HZ, requires 1 <= NUM_CH < DIV)
//     NUM_CH   number of timer channels
//     DUR_W    width of a channel duration, in ticks
//
//   Ports
//     clk      clock
//     rst      asynchronous, active-high reset
//     start    per-channel start strobe; loads dur and arms the channel
//     dur      flat duration bus, channel i on [i*DUR_W +: DUR_W]
//     cancel   per-channel abort strobe (no done pulse)
//     busy     channel armed and counting
//     done     one-cycle expiry pulse per channel (registered)
//     tick     one-cycle pulse at TICK_HZ
//     time_ms  free-running tick count since reset, wraps silently

module ms_timer_scheduler #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int NUM_CH  = 4,
  parameter int DUR_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH*DUR_W-1:0] dur,
  input  logic [NUM_CH-1:0]       cancel,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic                    tick,
  output logic [31:0]             time_ms
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CH - 1);

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_t;

  // ---------------------------------------------------------------------------
  // Prescaler, tick and free-running ms counter
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic          presc_wrap;
  logic [31:0]   time_ms_q;

  assign presc_wrap = (presc == PRESC_MAX);
  assign time_ms    = time_ms_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      tick      <= 1'b0;
      time_ms_q <= '0;
    end else begin
      presc     <= presc_wrap ? '0 : presc + PW'(1);
      tick      <= presc_wrap;
      // Written every cycle (adding 0 between ticks); 2^32-1 rolls over to 0.
      time_ms_q <= time_ms_q + {31'd0, presc_wrap};
    end
  end

  // ---------------------------------------------------------------------------
  // Sweep FSM: state register / next-state logic / output decode
  // ---------------------------------------------------------------------------
  state_t        state_q, state_nxt;
  logic [IW-1:0] idx_q, idx_nxt;
  logic          visit_en;
  logic [IW-1:0] visit_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_nxt = S_SWEEP;
          idx_nxt   = '0;
        end
      end
      S_SWEEP: begin
        if (idx_q == LAST_IDX) begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx_q + IW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    visit_en  = (state_q == S_SWEEP);
    visit_idx = idx_q;
  end

  // ---------------------------------------------------------------------------
  // Channels: start > cancel > sweep decrement, evaluated per channel
  // ---------------------------------------------------------------------------
  logic [DUR_W-1:0] rem [NUM_CH];

  // NOTE: rem is a small flop array rather than a RAM, so it is cleared by
  // reset like any other register; a reset mid-count must leave no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      done <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        rem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        done[i] <= 1'b0;
        if (start[i]) begin
          if (dur[i*DUR_W +: DUR_W] != '0) begin
            rem[i]  <= dur[i*DUR_W +: DUR_W];
            busy[i] <= 1'b1;
          end else begin
            // Zero-length start expires immediately without ever going busy.
            rem[i]  <= '0;
            busy[i] <= 1'b0;
            done[i] <= 1'b1;
          end
        end else if (cancel[i]) begin
          rem[i]  <= '0;
          busy[i] <= 1'b0;
        end else if (visit_en && (visit_idx == IW'(i)) && busy[i]) begin
          // Last count goes straight to 0 so remaining can never underflow.
          if (rem[i] == DUR_W'(1)) begin
            rem[i]  <= '0;
            busy[i] <= 1'b0;
            done[i] <= 1'b1;
          end else begin
            rem[i] <= rem[i] - DUR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ms_timer_scheduler.sv
// tb_ms_timer_scheduler
//   Directed bench for ms_timer_scheduler with CLK_HZ=10, TICK_HZ=1 (DIV=10),
//   NUM_CH=4, DUR_W=8. cyc counts rising edges since the last reset release,
//   so after edge Ek the bench sees cyc==k. Tick m rises after edge 10m and
//   channel i is visited by the edge 10m+2+i.

module tb_ms_timer_scheduler;

  localparam int NUM_CH = 4;
  localparam int DUR_W  = 8;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH*DUR_W-1:0] dur;
  logic [NUM_CH-1:0]       cancel;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic                    tick;
  logic [31:0]             time_ms;

  ms_timer_scheduler #(
    .CLK_HZ (10),
    .TICK_HZ(1),
    .NUM_CH (NUM_CH),
    .DUR_W  (DUR_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .dur    (dur),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .tick   (tick),
    .time_ms(time_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Done monitor: pulse count, cycle of last pulse, done-while-busy count.
  int done_cnt [NUM_CH];
  int done_cyc [NUM_CH];
  int overlap;
  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (done[i] === 1'b1) begin
        done_cnt[i] = done_cnt[i] + 1;
        done_cyc[i] = cyc;
      end
    end
    if ((done & busy) !== '0) overlap = overlap + 1;
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      step();
      guard++;
    end
    if (cyc != n) check("goto_cycle", cyc, n);
  endtask

  task automatic clear_monitor();
    for (int i = 0; i < NUM_CH; i++) begin
      done_cnt[i] = 0;
      done_cyc[i] = -1;
    end
    overlap = 0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    start  = '0;
    cancel = '0;
    dur    = '0;
    clear_monitor();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] c,
                       input logic [NUM_CH*DUR_W-1:0] d);
    start  = s;
    cancel = c;
    dur    = d;
    step();
    start  = '0;
    cancel = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    start  = '0;
    cancel = '0;
    dur    = '0;
    clear_monitor();
    step();
    step();
    check("rst_busy",    32'(busy), 32'h0);
    check("rst_done",    32'(done), 32'h0);
    check("rst_tick",    32'(tick), 32'h0);
    check("rst_time_ms", time_ms,   32'h0);
    rst = 1'b0;

    // ---- Reset mid-sweep ----
    pulse(4'b0100, 4'b0000, {8'd0, 8'd5, 8'd0, 8'd0});
    check("mid_busy_armed", 32'(busy), 32'h4);
    goto(13);
    check("mid_time_ms", time_ms, 32'd1);
    check("mid_rem2_before_visit", 32'(dut.rem[2]), 32'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_time_ms", time_ms, 32'h0);
    check("mid_rst_rem2", 32'(dut.rem[2]), 32'h0);
    do_reset();
    goto(9);
    check("mid_no_tick_at_9", 32'(tick), 32'h0);
    goto(10);
    check("mid_first_tick_at_10", 32'(tick), 32'h1);
    check("mid_time_ms_at_10", time_ms, 32'd1);
    goto(80);
    check("mid_no_done2", 32'(done_cnt[2]), 32'd0);
    check("mid_busy_idle", 32'(busy), 32'h0);

    // ---- Basic expiry ----
    do_reset();
    pulse(4'b0001, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd3});
    check("basic_busy", 32'(busy), 32'h1);
    check("basic_rem0", 32'(dut.rem[0]), 32'd3);
    goto(31);
    check("basic_busy_at_31", 32'(busy), 32'h1);
    check("basic_no_done_at_31", 32'(done), 32'h0);
    goto(32);
    check("basic_done_at_32", 32'(done), 32'h1);
    check("basic_busy_fell", 32'(busy), 32'h0);
    check("basic_time_ms", time_ms, 32'd3);
    goto(33);
    check("basic_done_one_cycle", 32'(done), 32'h0);
    goto(60);
    check("basic_done_cnt", 32'(done_cnt[0]), 32'd1);
    check("basic_overlap", 32'(overlap), 32'd0);

    // ---- Zero and restart ----
    do_reset();
    pulse(4'b0010, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd0});
    check("zero_done", 32'(done), 32'h2);
    check("zero_busy", 32'(busy), 32'h0);
    step();
    check("zero_done_cleared", 32'(done), 32'h0);
    pulse(4'b0010, 4'b0000, {8'd0, 8'd0, 8'd4, 8'd0});
    check("restart_busy", 32'(busy), 32'h2);
    check("restart_rem_first", 32'(dut.rem[1]), 32'd4);
    goto(21);
    check("restart_rem_after_tick1", 32'(dut.rem[1]), 32'd3);
    pulse(4'b0010, 4'b0000, {8'd0, 8'd0, 8'd2, 8'd0});
    check("restart_rem_reload", 32'(dut.rem[1]), 32'd2);
    goto(32);
    check("restart_rem_before_exp", 32'(dut.rem[1]), 32'd1);
    check("restart_no_done_yet", 32'(done), 32'h0);
    goto(33);
    check("restart_done_at_33", 32'(done), 32'h2);
    goto(60);
    check("restart_done_cnt", 32'(done_cnt[1]), 32'd2);
    check("restart_done_cyc", 32'(done_cyc[1]), 32'd33);
    check("restart_overlap", 32'(overlap), 32'd0);

    // ---- Cancel and precedence ----
    do_reset();
    pulse(4'b1100, 4'b0000, {8'd6, 8'd5, 8'd0, 8'd0});
    goto(13);
    // Start and cancel land on the same edge as the channel-2 visit.
    pulse(4'b0100, 4'b0100, {8'd6, 8'd2, 8'd0, 8'd0});
    check("prec_busy", 32'(busy), 32'hC);
    check("prec_rem2", 32'(dut.rem[2]), 32'd2);
    goto(26);
    check("cancel_rem3_before", 32'(dut.rem[3]), 32'd4);
    pulse(4'b0000, 4'b1000, {8'd6, 8'd2, 8'd0, 8'd0});
    check("cancel_busy", 32'(busy), 32'h4);
    check("cancel_rem3", 32'(dut.rem[3]), 32'd0);
    goto(80);
    check("cancel_no_done3", 32'(done_cnt[3]), 32'd0);
    check("prec_done2_cnt", 32'(done_cnt[2]), 32'd1);
    check("prec_done2_cyc", 32'(done_cyc[2]), 32'd34);
    check("cancel_all_idle", 32'(busy), 32'h0);

    // ---- Concurrent channels ----
    do_reset();
    pulse(4'b1111, 4'b0000, {8'd7, 8'd2, 8'd2, 8'd1});
    check("conc_busy", 32'(busy), 32'hF);
    goto(12);
    check("conc_done0", 32'(done), 32'h1);
    check("conc_busy_after0", 32'(busy), 32'hE);
    goto(23);
    check("conc_done1", 32'(done), 32'h2);
    goto(24);
    check("conc_done2", 32'(done), 32'h4);
    goto(90);
    check("conc_cyc3", 32'(done_cyc[3]), 32'd75);
    check("conc_cnt0", 32'(done_cnt[0]), 32'd1);
    check("conc_cnt1", 32'(done_cnt[1]), 32'd1);
    check("conc_cnt2", 32'(done_cnt[2]), 32'd1);
    check("conc_cnt3", 32'(done_cnt[3]), 32'd1);
    check("conc_overlap", 32'(overlap), 32'd0);

    // ---- time_ms wrap ----
    do_reset();
    pulse(4'b0001, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd2});
    goto(3);
    force dut.time_ms_q = 32'hFFFF_FFFF;
    step();
    release dut.time_ms_q;
    check("wrap_preload", time_ms, 32'hFFFF_FFFF);
    goto(10);
    check("wrap_tick", 32'(tick), 32'h1);
    check("wrap_time_ms_zero", time_ms, 32'h0);
    goto(22);
    check("wrap_done0", 32'(done), 32'h1);
    check("wrap_time_ms_after", time_ms, 32'd1);
    goto(30);
    check("wrap_done_cnt", 32'(done_cnt[0]), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
